red_wave_scheduler: RTL and testbench

Sequences the falling red rectangles of the freeze-tag playfield. It owns four rectangle slots and picks each slot's horizontal lane from an internal LFSR. It launches slots on a frame-paced schedule, retires them on hit or bottom-exit, and tracks hits, misses and wave number. It sits between the game-level start/frame logic and the per-rectangle drawing/vertical-counter instances, replacing their per-rectangle start/reset sequencing.

---
 rtl/red_wave_scheduler.sv | 167 ++++++++++++++++
 tb/tb_red_wave_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/red_wave_scheduler.sv
// Falling-rectangle sequencer: four slots, LFSR-chosen lanes, frame-paced launches,
// hit/miss retirement and wave progression for the freeze-tag playfield.
module red_wave_scheduler #(
    parameter int         LAUNCH_GAP = 30,
    parameter int         WAVE_LEN   = 8,
    parameter int         WAVE_PAUSE = 60,
    parameter int         MAX_MISS   = 3,
    parameter logic [9:0] LFSR_SEED  = 10'h2A5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        frame,
    input  logic [3:0]  slot_hit,
    input  logic [3:0]  slot_out,
    output logic [3:0]  launch,
    output logic [3:0]  slot_busy,
    output logic [39:0] hpos,
    output logic [7:0]  hits,
    output logic [3:0]  misses,
    output logic [3:0]  wave,
    output logic        playing,
    output logic        game_over
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, PAUSE, OVER} stateType;

    localparam logic [9:0]  GAP_BASE   = 10'(LAUNCH_GAP);
    localparam logic [7:0]  WAVE_LAST  = 8'(WAVE_LEN);
    localparam logic [15:0] PAUSE_LAST = 16'(WAVE_PAUSE - 1);
    localparam logic [4:0]  MISS_LIMIT = 5'(MAX_MISS);

    stateType    state;
    logic [9:0]  lfsr;
    logic [9:0]  gapCount;
    logic [7:0]  launchedCount;
    logic [15:0] pauseCount;
    logic [9:0]  laneReg [4];

    logic [3:0]  hitQual, outQual, freeMask, freeOneHot, launchFire, busyAfter;
    logic [8:0]  hitSum;
    logic [4:0]  missSum;
    logic [7:0]  hitsNext;
    logic [3:0]  missesNext;
    logic [9:0]  waveX2, gapEff, lane;
    logic        gapAtEnd, launchDue, overNow;

    function automatic logic [2:0] popCount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    always_comb begin
        hitQual    = (state == RUN) ? (slot_hit & slot_busy) : 4'b0000;
        // A same-cycle hit wins over an out on the same slot.
        outQual    = (state == RUN) ? (slot_out & slot_busy & ~slot_hit) : 4'b0000;
        hitSum     = {1'b0, hits} + 9'(popCount4(hitQual));
        missSum    = {1'b0, misses} + 5'(popCount4(outQual));
        hitsNext   = hitSum[8] ? 8'hFF : hitSum[7:0];
        missesNext = missSum[4] ? 4'hF : missSum[3:0];
        overNow    = (state == RUN) && (missSum >= MISS_LIMIT);

        waveX2     = {5'b00000, wave, 1'b0};
        gapEff     = (GAP_BASE > waveX2 + 10'd8) ? (GAP_BASE - waveX2) : 10'd8;
        gapAtEnd   = (gapCount == gapEff - 10'd1);
        launchDue  = (state == RUN) && frame && gapAtEnd && (launchedCount < WAVE_LAST);

        // Lowest free slot, judged on pre-cycle busy so a retiring slot is never reused at once.
        freeMask   = ~slot_busy;
        freeOneHot = freeMask & (~freeMask + 4'd1);
        launchFire = (launchDue && !overNow) ? freeOneHot : 4'b0000;
        busyAfter  = (slot_busy & ~(hitQual | outQual)) | launchFire;

        lane       = 10'd16 + {1'b0, lfsr[8:3], 3'b000};
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    laneReg[gi] <= '0;
                end else if (launchFire[gi]) begin
                    laneReg[gi] <= lane;
                end
            end
            assign hpos[gi*10 +: 10] = laneReg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            lfsr          <= LFSR_SEED;
            launch        <= '0;
            slot_busy     <= '0;
            hits          <= '0;
            misses        <= '0;
            wave          <= '0;
            playing       <= 1'b0;
            game_over     <= 1'b0;
            gapCount      <= '0;
            launchedCount <= '0;
            pauseCount    <= '0;
        end else begin
            lfsr   <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            launch <= '0;
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state         <= ARM;
                        hits          <= '0;
                        misses        <= '0;
                        wave          <= '0;
                        launchedCount <= '0;
                        gapCount      <= '0;
                        pauseCount    <= '0;
                        slot_busy     <= '0;
                        playing       <= 1'b0;
                        game_over     <= 1'b0;
                    end
                end
                ARM: begin
                    if (frame) begin
                        state   <= RUN;
                        playing <= 1'b1;
                    end
                end
                RUN: begin
                    hits   <= hitsNext;
                    misses <= missesNext;
                    if (overNow) begin
                        state     <= OVER;
                        slot_busy <= '0;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        slot_busy <= busyAfter;
                        launch    <= launchFire;
                        if (|launchFire) begin
                            launchedCount <= launchedCount + 8'd1;
                            gapCount      <= '0;
                        end else if (frame && !gapAtEnd) begin
                            gapCount <= gapCount + 10'd1;
                        end
                        if (launchedCount == WAVE_LAST && busyAfter == 4'b0000) begin
                            state      <= PAUSE;
                            pauseCount <= '0;
                        end
                    end
                end
                PAUSE: begin
                    if (frame) begin
                        if (pauseCount == PAUSE_LAST) begin
                            state         <= RUN;
                            wave          <= (wave == 4'hF) ? wave : wave + 4'd1;
                            launchedCount <= '0;
                            gapCount      <= '0;
                        end else begin
                            pauseCount <= pauseCount + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_red_wave_scheduler.sv
// Directed bench for red_wave_scheduler: launch timing, slot exhaustion, retirement,
// game over, wave pacing table and asynchronous reset.
module tb_red_wave_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, frame;
    logic [3:0]  slot_hit, slot_out;
    logic [3:0]  launch, slot_busy;
    logic [39:0] hpos;
    logic [7:0]  hits;
    logic [3:0]  misses, wave;
    logic        playing, game_over;

    always #5 clk = ~clk;

    red_wave_scheduler #(
        .LAUNCH_GAP(30), .WAVE_LEN(8), .WAVE_PAUSE(60), .MAX_MISS(3), .LFSR_SEED(10'h2A5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .frame(frame),
        .slot_hit(slot_hit), .slot_out(slot_out), .launch(launch), .slot_busy(slot_busy),
        .hpos(hpos), .hits(hits), .misses(misses), .wave(wave),
        .playing(playing), .game_over(game_over)
    );

    int checks   = 0;
    int failures = 0;
    int launchCount = 0;

    // Reference LFSR: 10-bit Fibonacci, taps 10 and 7, seed 0x2A5.
    logic [9:0] modelLfsr;
    logic [9:0] preLfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelLfsr <= 10'h2A5;
        else          modelLfsr <= {modelLfsr[8:0], modelLfsr[9] ^ modelLfsr[6]};
    end

    typedef struct {
        logic [3:0] expWave;
        int         expGap;
        logic [3:0] hitMask;
        logic [3:0] expSlot;
    } waveVec;
    waveVec waveTab[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] laneOf(input logic [9:0] l);
        return 10'd16 + {1'b0, l[8:3], 3'b000};
    endfunction

    task automatic cycle(input logic st, input logic fr, input logic [3:0] h, input logic [3:0] o);
        start = st; frame = fr; slot_hit = h; slot_out = o;
        preLfsr = modelLfsr;
        @(posedge clk); #1;
        start = 1'b0; frame = 1'b0; slot_hit = 4'b0000; slot_out = 4'b0000;
    endtask

    task automatic checkLane(input string name, input logic [3:0] vec);
        int idx;
        logic [9:0] h;
        idx = 0;
        for (int i = 0; i < 4; i++) if (vec[i]) idx = i;
        h = hpos[idx*10 +: 10];
        check(name, h, laneOf(preLfsr));
        check({name, "_range"}, (h >= 10'd16 && h <= 10'd520 && h[2:0] == 3'b000), 1);
    endtask

    task automatic waitLaunch(input int maxFrames, output int n, output logic [3:0] vec);
        n = 0;
        vec = 4'b0000;
        while (n < maxFrames && vec == 4'b0000) begin
            cycle(1'b0, 1'b1, 4'b0000, 4'b0000);
            n++;
            vec = launch;
        end
        if (vec != 4'b0000) begin
            launchCount++;
            $display("launch #%0d slots=%b after %0d frames hpos=%h wave=%0d",
                     launchCount, vec, n, hpos, wave);
            checkLane("lane", vec);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_launch"}, launch, 0);
        check({tag, "_busy"}, slot_busy, 0);
        check({tag, "_hpos_lo"}, hpos[19:0], 0);
        check({tag, "_hpos_hi"}, hpos[39:20], 0);
        check({tag, "_hits"}, hits, 0);
        check({tag, "_misses"}, misses, 0);
        check({tag, "_wave"}, wave, 0);
        check({tag, "_playing"}, playing, 0);
        check({tag, "_game_over"}, game_over, 0);
        check({tag, "_lfsr"}, dut.lfsr, 10'h2A5);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int expHits;
        int seen;
        logic [3:0] vec;

        // Gap per wave: max(8, 30 - 2*wave); every rectangle hit in slot 0.
        waveTab[0]  = '{4'd0,  30, 4'b0001, 4'b0001};
        waveTab[1]  = '{4'd1,  28, 4'b0001, 4'b0001};
        waveTab[2]  = '{4'd2,  26, 4'b0001, 4'b0001};
        waveTab[3]  = '{4'd3,  24, 4'b0001, 4'b0001};
        waveTab[4]  = '{4'd4,  22, 4'b0001, 4'b0001};
        waveTab[5]  = '{4'd5,  20, 4'b0001, 4'b0001};
        waveTab[6]  = '{4'd6,  18, 4'b0001, 4'b0001};
        waveTab[7]  = '{4'd7,  16, 4'b0001, 4'b0001};
        waveTab[8]  = '{4'd8,  14, 4'b0001, 4'b0001};
        waveTab[9]  = '{4'd9,  12, 4'b0001, 4'b0001};
        waveTab[10] = '{4'd10, 10, 4'b0001, 4'b0001};
        waveTab[11] = '{4'd11,  8, 4'b0001, 4'b0001};
        waveTab[12] = '{4'd12,  8, 4'b0001, 4'b0001};

        reset_n = 1'b0; start = 1'b0; frame = 1'b0; slot_hit = '0; slot_out = '0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        reset_n = 1'b1;

        // start with frame in IDLE: ARM only, then the next frame enters RUN.
        cycle(1'b1, 1'b1, 4'b0000, 4'b0000);
        check("arm_not_playing", playing, 0);
        cycle(1'b0, 1'b1, 4'b0000, 4'b0000);
        check("run_playing", playing, 1);

        // Basic launch and slot exhaustion.
        waitLaunch(60, n, vec);
        check("first_gap", n, 30);
        check("first_slot", vec, 4'b0001);
        check("first_busy", slot_busy, 4'b0001);
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000);
        check("launch_one_cycle", launch, 0);
        waitLaunch(60, n, vec);
        check("slot1_gap", n, 30);
        check("slot1", vec, 4'b0010);
        waitLaunch(60, n, vec);
        check("slot2_gap", n, 30);
        check("slot2", vec, 4'b0100);
        waitLaunch(60, n, vec);
        check("slot3_gap", n, 30);
        check("slot3", vec, 4'b1000);
        check("all_busy", slot_busy, 4'b1111);
        waitLaunch(40, n, vec);
        check("full_no_launch", vec, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0000, 4'b0100);
        check("out2_busy", slot_busy, 4'b1011);
        check("out2_misses", misses, 1);
        cycle(1'b0, 1'b1, 4'b0000, 4'b0000);
        check("held_launch", launch, 4'b0100);
        if (launch != 4'b0000) begin
            launchCount++;
            $display("launch #%0d slots=%b after held gap hpos=%h", launchCount, launch, hpos);
        end
        checkLane("held_lane", 4'b0100);
        check("held_busy", slot_busy, 4'b1111);

        // Retirement: single hit, then mixed hit/out with overlap on slot 1.
        cycle(1'b0, 1'b0, 4'b1000, 4'b0000);
        check("hit3_hits", hits, 1);
        check("hit3_busy", slot_busy, 4'b0111);
        cycle(1'b0, 1'b0, 4'b0011, 4'b0110);
        $display("retire hit=0011 out=0110 -> busy=%b hits=%0d misses=%0d", slot_busy, hits, misses);
        check("simul_hits", hits, 3);
        check("simul_misses", misses, 2);
        check("simul_busy", slot_busy, 4'b0000);
        cycle(1'b0, 1'b0, 4'b1111, 4'b1111);
        check("idle_pulse_hits", hits, 3);
        check("idle_pulse_misses", misses, 2);

        // Game over on the third miss.
        waitLaunch(60, n, vec);
        check("pre_over_gap", n, 30);
        check("pre_over_slot", vec, 4'b0001);
        cycle(1'b0, 1'b0, 4'b0000, 4'b0001);
        check("over_flag", game_over, 1);
        check("over_playing", playing, 0);
        check("over_misses", misses, 3);
        check("over_busy", slot_busy, 0);
        waitLaunch(40, n, vec);
        check("over_no_launch", vec, 4'b0000);
        cycle(1'b0, 1'b0, 4'b1111, 4'b1111);
        check("over_hits_frozen", hits, 3);
        check("over_misses_frozen", misses, 3);
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000);
        check("rearm_hits", hits, 0);
        check("rearm_misses", misses, 0);
        check("rearm_wave", wave, 0);
        check("rearm_over", game_over, 0);
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000);
        check("arm_ignores_start", playing, 0);
        cycle(1'b0, 1'b1, 4'b0000, 4'b0000);
        check("rerun_playing", playing, 1);

        // Wave pacing table.
        expHits = 0;
        for (int r = 0; r < 13; r++) begin
            for (int k = 0; k < 8; k++) begin
                waitLaunch(60, n, vec);
                check("wave_gap", n, waveTab[r].expGap);
                check("wave_slot", vec, waveTab[r].expSlot);
                check("wave_num", wave, waveTab[r].expWave);
                cycle(1'b0, 1'b0, waveTab[r].hitMask, 4'b0000);
                expHits++;
                check("wave_hits", hits, expHits);
            end
            seen = 0;
            for (int f = 0; f < 59; f++) begin
                cycle(1'b0, 1'b1, 4'b0000, 4'b0000);
                if (launch != 4'b0000) seen++;
            end
            check("pause_quiet", seen, 0);
            check("pause_wave_held", wave, waveTab[r].expWave);
            check("pause_playing", playing, 1);
            cycle(1'b0, 1'b1, 4'b0000, 4'b0000);
            $display("wave %0d done -> wave=%0d hits=%0d", r, wave, hits);
            check("pause_end_wave", wave, waveTab[r].expWave + 1);
        end

        // Wave 13: gap floored at 8; reset while launch is high.
        waitLaunch(60, n, vec);
        check("floor_gap", n, 8);
        check("reset_pre_launch", launch, 4'b0001);
        reset_n = 1'b0;
        #1;
        checkReset("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
